// File: rtl/mode_gen_pkg.sv
// Shared mode codes for the digital clock.
// The timer, setup, alarm and clock blocks import this package.
package mode_gen_pkg;

    // Major mode codes.
    typedef enum logic [1:0] {
        M1_CLOCK = 2'd0,
        M1_SETUP = 2'd1,
        M1_ALARM = 2'd2,
        M1_TIMER = 2'd3
    } mode1_e;

    // Minor mode codes. The same value means different things in different major modes.
    localparam logic [1:0] M2_CLOCK_NORM = 2'd0;

    localparam logic [1:0] SET_HOUR      = 2'd0;
    localparam logic [1:0] SET_MIN       = 2'd1;
    localparam logic [1:0] SET_SEC       = 2'd2;

    localparam logic [1:0] ALM_HOUR      = 2'd0;
    localparam logic [1:0] ALM_MIN       = 2'd1;

    localparam logic [1:0] TIMER_G       = 2'd0;
    localparam logic [1:0] TIMER_START   = 2'd1;
    localparam logic [1:0] TIMER_STOP    = 2'd2;

    // Value 3 is never produced. If it ever appears, it is cleared on the next clock.
    localparam logic [1:0] M2_ILLEGAL    = 2'd3;

    // Number of bits needed to hold the given value. The result is at least 1.
    function automatic int unsigned bits_required(input int unsigned value);
        int unsigned n;
        n = 1;
        for (int i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, level debouncer and
// registered one-cycle press pulse (rising edge of debounced level).
module btn_debounce
    import mode_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned        CntW    = bits_required(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]    CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            level_dly_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Two-stage synchroniser for the asynchronous button pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
    // Any matching sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Debounced level, counter and the registered rising-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q     <= 1'b0;
            cnt_q       <= '0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mode_gen.sv
// Mode generator: debounces mode/sel/set buttons and drives the major and
// minor mode codes plus a one-cycle field increment strobe.
module mode_gen
    import mode_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_set,
    output logic [1:0] mode1,
    output logic [1:0] mode2,
    output logic       inc_pulse
);

    logic       mode_ev, sel_ev, set_ev;
    mode1_e     mode1_q, mode1_d;
    logic [1:0] mode2_q, mode2_d;
    logic       inc_q, inc_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_sel),
        .press (sel_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_set),
        .press (set_ev)
    );

    // Next-state logic. Priority is mode > sel > set. Losing events are dropped.
    always_comb begin
        mode1_d = mode1_q;
        mode2_d = (mode2_q == M2_ILLEGAL) ? M2_CLOCK_NORM : mode2_q;
        inc_d   = 1'b0;

        if (mode_ev) begin
            mode2_d = M2_CLOCK_NORM;
            unique case (mode1_q)
                M1_CLOCK: mode1_d = M1_SETUP;
                M1_SETUP: mode1_d = M1_ALARM;
                M1_ALARM: mode1_d = M1_TIMER;
                M1_TIMER: mode1_d = M1_CLOCK;
                default:  mode1_d = M1_CLOCK;
            endcase
        end else begin
            unique case (mode1_q)
                M1_CLOCK: begin
                    mode2_d = M2_CLOCK_NORM;
                end
                M1_SETUP: begin
                    if (sel_ev) begin
                        case (mode2_q)
                            SET_HOUR: mode2_d = SET_MIN;
                            SET_MIN:  mode2_d = SET_SEC;
                            default:  mode2_d = SET_HOUR;
                        endcase
                    end else if (set_ev) begin
                        inc_d = 1'b1;
                    end
                end
                M1_ALARM: begin
                    if (sel_ev) begin
                        mode2_d = (mode2_q == ALM_HOUR) ? ALM_MIN : ALM_HOUR;
                    end else if (set_ev) begin
                        inc_d = 1'b1;
                    end
                end
                M1_TIMER: begin
                    if (sel_ev) begin
                        case (mode2_q)
                            TIMER_G:     mode2_d = TIMER_START;
                            TIMER_START: mode2_d = TIMER_STOP;
                            TIMER_STOP:  mode2_d = TIMER_START;
                            default:     mode2_d = TIMER_G;
                        endcase
                    end else if (set_ev && mode2_q == TIMER_STOP) begin
                        mode2_d = TIMER_G;
                    end
                end
                default: begin
                    mode1_d = M1_CLOCK;
                    mode2_d = M2_CLOCK_NORM;
                end
            endcase
        end
    end

    // Mode and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode1_q <= M1_CLOCK;
            mode2_q <= M2_CLOCK_NORM;
            inc_q   <= 1'b0;
        end else begin
            mode1_q <= mode1_d;
            mode2_q <= mode2_d;
            inc_q   <= inc_d;
        end
    end

    assign mode1     = mode1_q;
    assign mode2     = mode2_q;
    assign inc_pulse = inc_q;

endmodule
